// File: rtl/spi_word_rx.sv
// Purpose: SPI mode-0 receive endpoint; oversamples cs/sclk/sdi on clk and reassembles WIDTH-bit words.
// Latency: data/data_valid update on the 2nd clk edge after the edge that first samples the final sclk high.
// Backpressure: none; data_valid is a one-cycle pulse and the consumer must take it when it appears.
//
// Ports:
//   clk        system clock, all logic on its rising edge
//   rst        synchronous active-high reset
//   cs         chip select, active low, asynchronous
//   sclk       serial clock, asynchronous, idles low
//   sdi        serial data, valid at sclk rising edge
//   data       last complete received word (held until the next data_valid)
//   data_valid one-cycle pulse when data updates
//   frame_err  one-cycle pulse when cs rises with a partial word collected
//   busy       high while a frame is active (synchronised cs low)
module spi_word_rx #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cs,
  input  logic             sclk,
  input  logic             sdi,
  output logic [WIDTH-1:0] data,
  output logic             data_valid,
  output logic             frame_err,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  state_t state, state_nxt;

  // Two-flop synchronisers plus one delay flop on cs and sclk for edge detection.
  // cs resets high so a frame only starts on an observed high-to-low transition.
  logic cs_s1, cs_s2, cs_d;
  logic sclk_s1, sclk_s2, sclk_d;
  logic sdi_s1, sdi_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_d    <= 1'b1;
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_d  <= 1'b0;
      sdi_s1  <= 1'b0;
      sdi_s2  <= 1'b0;
    end else begin
      cs_s1   <= cs;
      cs_s2   <= cs_s1;
      cs_d    <= cs_s2;
      sclk_s1 <= sclk;
      sclk_s2 <= sclk_s1;
      sclk_d  <= sclk_s2;
      sdi_s1  <= sdi;
      sdi_s2  <= sdi_s1;
    end
  end

  logic sclk_rise, cs_fall, cs_rise;
  assign sclk_rise = sclk_s2 & ~sclk_d;
  assign cs_fall   = ~cs_s2 & cs_d;
  assign cs_rise   = cs_s2 & ~cs_d;

  logic [CW-1:0]    bitcnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shifted;

  // Shift direction decides where the first bit ends up once the word is full.
  assign shifted = MSB_FIRST ? {shreg[WIDTH-2:0], sdi_s2} : {sdi_s2, shreg[WIDTH-1:1]};

  logic start, shift_en, word_done, abort;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // cs_rise has priority over a coincident sclk_rise: that bit is dropped and
  // the partial-word test uses the count from before the dropped edge.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    shift_en  = 1'b0;
    word_done = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_nxt = ACTIVE;
          start     = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_nxt = IDLE;
          abort     = (bitcnt != '0);
        end else if (sclk_rise) begin
          shift_en  = 1'b1;
          word_done = (bitcnt == LAST_BIT);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bitcnt     <= '0;
      shreg      <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= word_done;
      frame_err  <= abort;
      if (start || abort) begin
        bitcnt <= '0;
        shreg  <= '0;
      end else if (shift_en) begin
        if (word_done) begin
          data   <= shifted;
          bitcnt <= '0;
          shreg  <= '0;
        end else begin
          shreg  <= shifted;
          bitcnt <= bitcnt + CW'(1);
        end
      end
    end
  end

  assign busy = (state == ACTIVE);

endmodule

// File: tb/tb_spi_word_rx.sv
module tb_spi_word_rx;

  localparam int W    = 16;
  localparam int MAXC = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cs  = 1'b1;
  logic sclk = 1'b0;
  logic sdi = 1'b0;

  logic [W-1:0] data_m, data_l;
  logic dv_m, dv_l, fe_m, fe_l, busy_m, busy_l;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_word_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .cs(cs), .sclk(sclk), .sdi(sdi),
    .data(data_m), .data_valid(dv_m), .frame_err(fe_m), .busy(busy_m)
  );

  spi_word_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .cs(cs), .sclk(sclk), .sdi(sdi),
    .data(data_l), .data_valid(dv_l), .frame_err(fe_l), .busy(busy_l)
  );

  // Transaction-level model: bus events are timestamped by the cycle the
  // driver changed the pins; their visible effect lands 3 cycles later
  // (one cycle to reach the first sampling edge, then the 2-edge latency).
  bit           s_dv   [MAXC];
  bit           s_fe   [MAXC];
  bit           s_rst  [MAXC];
  bit           s_bset [MAXC];
  bit           s_bval [MAXC];
  logic [W-1:0] s_dm   [MAXC];
  logic [W-1:0] s_dl   [MAXC];
  bit           in_frame = 1'b0;
  bit           bits[$];

  function automatic void m_cs_fall(int c);
    if (!in_frame && c + 3 < MAXC) begin
      in_frame = 1'b1;
      bits.delete();
      s_bset[c+3] = 1'b1;
      s_bval[c+3] = 1'b1;
    end
  endfunction

  function automatic void m_cs_rise(int c);
    if (in_frame && c + 3 < MAXC) begin
      if (bits.size() != 0) s_fe[c+3] = 1'b1;
      bits.delete();
      in_frame = 1'b0;
      s_bset[c+3] = 1'b1;
      s_bval[c+3] = 1'b0;
    end
  endfunction

  function automatic void m_sclk_rise(int c, bit b);
    logic [W-1:0] wm, wl;
    if (!in_frame || c + 3 >= MAXC) return;
    bits.push_back(b);
    if (bits.size() == W) begin
      wm = '0;
      wl = '0;
      for (int i = 0; i < W; i++) begin
        wm[W-1-i] = bits[i];   // first bit received is the MSB
        wl[i]     = bits[i];   // first bit received is the LSB
      end
      s_dv[c+3] = 1'b1;
      s_dm[c+3] = wm;
      s_dl[c+3] = wl;
      bits.delete();
    end
  endfunction

  function automatic void m_reset(int c);
    for (int k = c + 1; k <= c + 3 && k < MAXC; k++) begin
      s_dv[k]   = 1'b0;
      s_fe[k]   = 1'b0;
      s_bset[k] = 1'b0;
    end
    if (c + 1 < MAXC) s_rst[c+1] = 1'b1;
    in_frame = 1'b0;
    bits.delete();
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  // Per-cycle compare against the model.
  logic [W-1:0] e_dm = '0;
  logic [W-1:0] e_dl = '0;
  bit           e_busy = 1'b0;
  int           dv_cnt = 0;
  int           fe_cnt = 0;
  int           dv_cycles[$];

  always @(negedge clk) begin
    if (cyc >= 1 && cyc < MAXC) begin
      if (s_rst[cyc]) begin
        e_dm   = '0;
        e_dl   = '0;
        e_busy = 1'b0;
      end
      if (s_bset[cyc]) e_busy = s_bval[cyc];
      if (s_dv[cyc]) begin
        e_dm = s_dm[cyc];
        e_dl = s_dl[cyc];
      end
      chk("dv_m",   {15'd0, dv_m},   {15'd0, s_dv[cyc]});
      chk("dv_l",   {15'd0, dv_l},   {15'd0, s_dv[cyc]});
      chk("fe_m",   {15'd0, fe_m},   {15'd0, s_fe[cyc]});
      chk("fe_l",   {15'd0, fe_l},   {15'd0, s_fe[cyc]});
      chk("busy_m", {15'd0, busy_m}, {15'd0, e_busy});
      chk("busy_l", {15'd0, busy_l}, {15'd0, e_busy});
      chk("data_m", data_m, e_dm);
      chk("data_l", data_l, e_dl);
      chk("dv_fe_excl", {15'd0, dv_m & fe_m}, 16'd0);
      if (dv_m === 1'b1) begin
        dv_cnt++;
        dv_cycles.push_back(cyc);
      end
      if (fe_m === 1'b1) fe_cnt++;
    end
  end

  // Drivers: pins change on the falling clk edge.
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_down();
    @(negedge clk);
    cs = 1'b0;
    m_cs_fall(cyc);
  endtask

  task automatic cs_up();
    @(negedge clk);
    sclk = 1'b0;
    @(negedge clk);
    cs = 1'b1;
    m_cs_rise(cyc);
  endtask

  // 4 clk per bit: sclk low 2 cycles (sdi set at the fall), high 2 cycles.
  task automatic send_bit(input bit b);
    @(negedge clk);
    sclk = 1'b0;
    sdi  = b;
    repeat (2) @(negedge clk);
    sclk = 1'b1;
    m_sclk_rise(cyc, b);
    @(negedge clk);
  endtask

  task automatic send_bits(input logic [W-1:0] v, input int n);
    for (int i = 0; i < n; i++) send_bit(v[W-1-i]);
  endtask

  task automatic frame(input logic [W-1:0] v);
    cs_down();
    idle(3);
    send_bits(v, W);
    cs_up();
    idle(6);
  endtask

  int dv0, fe0;
  logic [W-1:0] v;

  initial begin
    // Reset
    idle(4);
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    chk("lit_reset_data", data_m, 16'h0000);
    chk("lit_reset_busy", {15'd0, busy_m}, 16'd0);

    // Single word
    dv0 = dv_cnt; fe0 = fe_cnt;
    frame(16'hA5C3);
    chk("lit_single_m", data_m, 16'hA5C3);
    chk("lit_single_l", data_l, 16'hC3A5);
    chk("lit_single_dvcnt", 16'(dv_cnt - dv0), 16'd1);
    chk("lit_single_fecnt", 16'(fe_cnt - fe0), 16'd0);

    // Two words in one frame
    dv0 = dv_cnt;
    dv_cycles.delete();
    cs_down();
    idle(3);
    send_bits(16'h0001, W);
    send_bits(16'hFFFE, W);
    cs_up();
    idle(6);
    chk("lit_b2b_dvcnt", 16'(dv_cnt - dv0), 16'd2);
    if (dv_cycles.size() == 2) chk("lit_b2b_gap", 16'(dv_cycles[1] - dv_cycles[0]), 16'd64);
    else chk("lit_b2b_pulses", 16'(dv_cycles.size()), 16'd2);
    chk("lit_b2b_m", data_m, 16'hFFFE);
    chk("lit_b2b_l", data_l, 16'h7FFF);

    // Aborted word
    frame(16'h1234);
    dv0 = dv_cnt; fe0 = fe_cnt;
    cs_down();
    idle(3);
    send_bits(16'hABCD, 7);
    cs_up();
    idle(6);
    chk("lit_abort_fecnt", 16'(fe_cnt - fe0), 16'd1);
    chk("lit_abort_dvcnt", 16'(dv_cnt - dv0), 16'd0);
    chk("lit_abort_hold", data_m, 16'h1234);
    frame(16'h00FF);
    chk("lit_after_abort_m", data_m, 16'h00FF);
    chk("lit_after_abort_l", data_l, 16'hFF00);

    // First bit 1, rest 0
    frame(16'h8000);
    chk("lit_lsb_l", data_l, 16'h0001);
    chk("lit_lsb_m", data_m, 16'h8000);

    // Reset mid-frame after 9 bits
    dv0 = dv_cnt; fe0 = fe_cnt;
    cs_down();
    idle(3);
    send_bits(16'hBEEF, 9);
    @(negedge clk);
    rst  = 1'b1;
    cs   = 1'b1;
    sclk = 1'b0;
    m_reset(cyc);
    @(negedge clk);
    rst = 1'b0;
    idle(6);
    chk("lit_rst_data", data_m, 16'h0000);
    chk("lit_rst_busy", {15'd0, busy_m}, 16'd0);
    chk("lit_rst_pulses", 16'(dv_cnt - dv0 + fe_cnt - fe0), 16'd0);
    frame(16'hBEEF);
    chk("lit_rst_refill", data_m, 16'hBEEF);

    // cs rise in the same cycle as the 16th sclk rise
    dv0 = dv_cnt; fe0 = fe_cnt;
    v = 16'h5A5A;
    cs_down();
    idle(3);
    send_bits(v, W - 1);
    @(negedge clk);
    sclk = 1'b0;
    sdi  = v[0];
    repeat (2) @(negedge clk);
    sclk = 1'b1;
    cs   = 1'b1;
    m_cs_rise(cyc);
    idle(4);
    sclk = 1'b0;
    idle(4);
    chk("lit_coll_fecnt", 16'(fe_cnt - fe0), 16'd1);
    chk("lit_coll_dvcnt", 16'(dv_cnt - dv0), 16'd0);
    chk("lit_coll_hold", data_m, 16'hBEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1000000;
    mismatched++;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/spi_word_rx.md
Name: spi_word_rx

Overview:
- Receive-side SPI endpoint. Accepts the chip-select / serial-clock / serial-data stream that the team's counter SPI transmitter drives, and reassembles it into parallel words in the system clock domain.
- Acts as the loopback checker and the downstream consumer for that transmitter.
- The SPI inputs are treated as asynchronous. They are oversampled by clk, so the block has no second clock domain.

Parameters:
- WIDTH, 16, bits per received word; must be >= 2.
- MSB_FIRST, 1, 1 = first received bit lands in data[WIDTH-1]; 0 = first received bit lands in data[0].

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- cs  input  1  chip select, active low, asynchronous.
- sclk  input  1  serial clock, asynchronous, idles low (SPI mode 0).
- sdi  input  1  serial data; valid at sclk rising edge.
- data  output  WIDTH  last complete received word.
- data_valid  output  1  one-cycle pulse when data updates.
- frame_err  output  1  one-cycle pulse when cs rises mid-word.
- busy  output  1  high while a frame is active (synchronised cs low).

Behaviour:
- Clock and reset: one clock domain (clk); rst is synchronous and active-high.
- Synchronisers: cs, sclk and sdi each pass through a 2-flop synchroniser; cs resets to 1, sclk and sdi reset to 0.
- Edge detection: one extra delay flop per synchronised cs and sclk.
  - sclk_rise = sync high & delayed low.
  - cs_fall / cs_rise are defined the same way.
- Input timing requirement: sclk high and low phases each >= 2 clk periods, and sdi stable around them. Behaviour outside this is undefined and is not checked by the block.
- State machine:
  - IDLE: busy=0.
    - On cs_fall, go to ACTIVE.
    - bitcnt <= 0 and the shift register is cleared.
  - ACTIVE: busy=1.
    - On each sclk_rise: shift in the synchronised sdi; bitcnt++.
    - When bitcnt reaches WIDTH-1 and sclk_rise occurs: data <= completed word; data_valid=1 for exactly one cycle; bitcnt <= 0.
    - Multi-word frames are supported: stay in ACTIVE and collect the next word.
    - On cs_rise: go to IDLE. If bitcnt != 0, pulse frame_err for one cycle and discard the partial word; data is unchanged.
- Simultaneous sclk_rise and cs_rise in the same cycle: cs_rise wins. The bit is not captured and bitcnt is evaluated before the discarded edge.
- sclk_rise while in IDLE (cs high) is ignored.
- Latency: let E0 be the first clk edge at which raw sclk (final bit) is sampled high. data and data_valid update at edge E0+2 and are visible in the following cycle.
- Reset values:
  - data = 0, data_valid = 0, frame_err = 0, busy = 0.
  - State IDLE, bitcnt = 0, shift register = 0.
- Reset mid-frame: everything returns to the reset values, with no data_valid or frame_err pulse. After rst falls, cs must be seen high then falling to start a new frame. A cs that is already low when rst falls does not start a frame, because the cs synchroniser reset value is 1 and cs_fall therefore only occurs on a real high-to-low transition.
- Output stability: data holds its value until the next data_valid. data_valid and frame_err are never high in the same cycle.

Test Plan:
- Single word: WIDTH=16, MSB_FIRST=1; cs low, shift 0xA5C3 with sclk = 4 clk periods per bit, cs high → one data_valid pulse; data=16'hA5C3; frame_err never asserted; busy high only between cs edges (+ sync delay).
- Back-to-back in one frame: shift 0x0001 then 0xFFFE without raising cs → two data_valid pulses 64 clk apart; data = 0x0001 then 0xFFFE.
- Aborted word: after a good 0x1234, cs low, 7 bits, cs high → frame_err one cycle; no data_valid; data stays 0x1234. Next full frame with 0x00FF → data=0x00FF.
- LSB-first: MSB_FIRST=0, send bit sequence 1,0,0,...,0 → data=16'h0001.
- Reset mid-frame: rst asserted for 1 cycle after 9 bits of 0xBEEF → data=0, busy=0, no pulses. Then a fresh cs fall and 0xBEEF → data=0xBEEF.
- Edge collision: cs rise in the same clk cycle as the 16th sclk_rise (force the synchronised inputs) → frame_err pulse, no data_valid.
